ram4_bank: RTL and testbench
============================

Name: ram4_bank

Overview:
- Four-word register bank that consumes the one-hot load strobes of a 4-way demux stage. Address bits select which word the `load` pulse writes.
- Read is combinational: `out` always shows `word[address]`.
- Adds a sequenced bulk-clear engine that zeroes the bank one word per cycle. RAM16/RAM64 composites use it for power-on and software-initiated wipes.

Parameters:
- WIDTH, 16, data word width in bits.

Ports:
- clk  input  1  rising-edge clock; all state updates on this edge.
- reset  input  1  synchronous, active-high reset.
- in  input  WIDTH  write data.
- load  input  1  write strobe; demuxed by address to exactly one word.
- address  input  2  word select for both write and read.
- clear_req  input  1  pulse/level request to start a bulk clear.
- out  output  WIDTH  combinational read data = word[address].
- busy  output  1  high while the clear engine is running.
- clear_done  output  1  single-cycle pulse on the cycle after the last word is cleared.

Behaviour:
- Storage: word[0..3], each WIDTH bits.
- Write decode:
  - Internal one-hot `ld[3:0]` per the 4-way demux mapping: ld[0] for address 00, ld[1] for 01, ld[2] for 10, ld[3] for 11.
  - `ld[i] = load & (address == i)`. At most one word is written per cycle.
- Normal write: when state = IDLE and load=1, `word[address] <= in` at the clk edge. New data is visible on `out` the cycle after the edge, or the same cycle post-edge for combinational readers.
- Read: `out = word[address]` at all times, including while busy. There is no read latency and no read-during-write bypass: the old value shows until the edge.
- Reset (reset=1 at edge):
  - all words = 0; state = IDLE; busy = 0; clear_done = 0.
  - Reset overrides load and clear_req in the same cycle.
  - Reset mid-clear aborts the sequence; all words are zero anyway.
- Clear state machine, states IDLE, CLR0, CLR1, CLR2, CLR3, DONE:
  - IDLE: clear_req=1 -> CLR0. Otherwise stay in IDLE.
  - CLR0: word[0] <= 0 -> CLR1.
  - CLR1: word[1] <= 0 -> CLR2.
  - CLR2: word[2] <= 0 -> CLR3.
  - CLR3: word[3] <= 0 -> DONE.
  - DONE: clear_done=1 for this cycle only -> IDLE. A clear_req seen in DONE is ignored; a new clear must be requested from IDLE.
- busy is 1 in CLR0..CLR3. It is 0 in IDLE and DONE. Outputs are decoded from the registered state (Moore).
- Latency: with clear_req sampled high at edge N, busy=1 for cycles N+1..N+4, clear_done=1 in cycle N+5, and IDLE again from N+6. Word k reads 0 from cycle N+2+k.
- Conflicts:
  - load while busy=1 or in DONE: the write is dropped with no side effects.
  - load and clear_req both high in IDLE: clear wins and the write is dropped.
  - clear_req held high continuously restarts a new clear only after returning to IDLE. It does not re-trigger mid-sequence.
- Address wrap: the 2-bit address covers all four words. There are no out-of-range cases.

Test Plan:
- Reset then read: assert reset 1 cycle; sweep address 0..3 -> out = 0x0000 each; busy=0; clear_done=0.
- Directed writes: load=1 with (addr 0, 0x1234), (1, 0xABCD), (2, 0x00FF), (3, 0x8001) on consecutive cycles. Then read back -> exact values, and no cross-write into other words (checks demux one-hot).
- Write without load: load=0, in=0xFFFF, addr 2 -> word[2] stays 0x00FF.
- Bulk clear timing: after the writes above, pulse clear_req at edge N:
  - busy=1 at N+1..N+4; clear_done=1 only at N+5.
  - With address=3 held, out = 0x8001 through N+4 and 0x0000 from N+5.
  - All words read 0 afterward.
- Conflicts:
  - load=1 (addr 1, 0x5555) together with clear_req in IDLE -> word[1] = 0 after the sequence.
  - load=1 (addr 0, 0x7777) at N+2 while busy -> word[0] stays 0.
  - Write 0x7777 to addr 0 one cycle after clear_done -> accepted.
- Reset mid-clear: write 0xBEEF to all words, start clear, assert reset at N+2 -> next cycle busy=0, clear_done never pulses, and all words read 0.

Source files
------------

// File: rtl/ram4_bank.sv
// ram4_bank: four-word register bank with a sequenced one-word-per-cycle bulk-clear engine.
// Latency: read is combinational; a write shows after its edge; a clear runs 4 busy cycles then a 1-cycle done pulse.
// Backpressure: none; loads arriving while clearing or in DONE are dropped, and clear_req outside IDLE is ignored.
module ram4_bank #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [1:0]       address,
  input  logic             clear_req,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             clear_done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR0 = 3'd1,
    CLR1 = 3'd2,
    CLR2 = 3'd3,
    CLR3 = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] word [4];
  logic [3:0]       ld;
  logic [3:0]       clr;
  logic             wr_en;

  // A write is only honoured in IDLE, and a simultaneous clear request wins over it.
  assign wr_en = (state == IDLE) && load && !clear_req;

  // One-hot load strobes from the address demux, and one-hot clear strobes from the sequencer.
  always_comb begin
    ld  = '0;
    clr = '0;
    for (int i = 0; i < 4; i++) begin
      ld[i] = wr_en && (address == 2'(i));
    end
    clr[0] = (state == CLR0);
    clr[1] = (state == CLR1);
    clr[2] = (state == CLR2);
    clr[3] = (state == CLR3);
  end

  // Read path has no bypass: the pre-edge value shows until the write lands.
  assign out = word[address];

  // Storage update: reset zeroes everything, the sequencer zeroes one word per cycle, else demuxed load.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        word[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (clr[i]) begin
          word[i] <= '0;
        end else if (ld[i]) begin
          word[i] <= in;
        end
      end
    end
  end

  // Clear sequencer with registered Moore outputs; a held request restarts only after returning to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_req) begin
            state <= CLR0;
            busy  <= 1'b1;
          end
        end
        CLR0: state <= CLR1;
        CLR1: state <= CLR2;
        CLR2: state <= CLR3;
        CLR3: begin
          state      <= DONE;
          busy       <= 1'b0;
          clear_done <= 1'b1;
        end
        DONE: begin
          state      <= IDLE;
          clear_done <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          clear_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram4_bank.sv
// tb_ram4_bank: table vectors, directed clear/conflict/reset sequences and random traffic vs a timeline model.
// Latency: the model tracks a clear as "edges since the request was sampled".
// Backpressure: not applicable; the bench drives every cycle.
module tb_ram4_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] din;
  logic        load;
  logic [1:0]  address;
  logic        clear_req;
  logic [15:0] out;
  logic        busy;
  logic        clear_done;

  int tests = 0;
  int fails = 0;

  // Reference model: plain array plus the edge index at which the active clear was accepted.
  logic [15:0] mem [4];
  bit          active;
  int          start_edge;
  int          edge_cnt;

  typedef struct {
    logic        ld;
    logic [1:0]  addr;
    logic [15:0] data;
    logic [15:0] exp_out;
  } vec_t;

  vec_t vecs [8];

  ram4_bank #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (din),
    .load      (load),
    .address   (address),
    .clear_req (clear_req),
    .out       (out),
    .busy      (busy),
    .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Phase of the current interval: 1..4 clearing, 5 done, >=6 idle again.
  function automatic int phase();
    return active ? (edge_cnt - start_edge + 1) : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Advance one clock edge and apply the specified rules to the model.
  task automatic tick();
    int p;
    bit idle;
    p    = phase();
    idle = !active || (p >= 6);
    @(posedge clk);
    edge_cnt++;
    if (reset) begin
      for (int i = 0; i < 4; i++) mem[i] = '0;
      active = 1'b0;
    end else begin
      if (active && p >= 1 && p <= 4) mem[p-1] = '0;
      if (idle) begin
        if (clear_req) begin
          active     = 1'b1;
          start_edge = edge_cnt;
        end else if (load) begin
          mem[address] = din;
        end
      end
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    int p;
    p = phase();
    check({tag, "_out"},  out,        mem[address]);
    check({tag, "_busy"}, busy,       active && p >= 1 && p <= 4);
    check({tag, "_done"}, clear_done, active && p == 5);
  endtask

  task automatic sweep(input string tag, input logic [15:0] expv);
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      check($sformatf("%s_w%0d", tag, a), out, expv);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 2'd0, 16'h1234, 16'h1234};
    vecs[1] = '{1'b1, 2'd1, 16'hABCD, 16'hABCD};
    vecs[2] = '{1'b1, 2'd2, 16'h00FF, 16'h00FF};
    vecs[3] = '{1'b1, 2'd3, 16'h8001, 16'h8001};
    vecs[4] = '{1'b0, 2'd2, 16'hFFFF, 16'h00FF};
    vecs[5] = '{1'b0, 2'd0, 16'h0000, 16'h1234};
    vecs[6] = '{1'b0, 2'd1, 16'h0000, 16'hABCD};
    vecs[7] = '{1'b0, 2'd3, 16'h0000, 16'h8001};

    reset = 1'b1; load = 1'b0; clear_req = 1'b0; din = '0; address = '0;
    edge_cnt = 0; active = 1'b0; start_edge = 0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state.
    sweep("reset", 16'h0000);
    check("reset_busy", busy, 1'b0);
    check("reset_done", clear_done, 1'b0);

    // Directed writes, write-without-load and read-back.
    for (int i = 0; i < 8; i++) begin
      load = vecs[i].ld; address = vecs[i].addr; din = vecs[i].data;
      tick();
      check($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
      check_model($sformatf("vec%0d", i));
    end
    load = 1'b0;

    // Bulk-clear timing with address 3 held.
    address = 2'd3;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      check($sformatf("clr_n%0d_busy", k), busy, k <= 4);
      check($sformatf("clr_n%0d_done", k), clear_done, k == 5);
      check($sformatf("clr_n%0d_out", k), out, (k <= 4) ? 16'h8001 : 16'h0000);
      if (k < 6) tick();
    end
    sweep("after_clr", 16'h0000);

    // Load together with clear_req in IDLE: clear wins.
    address = 2'd1; din = 16'h5555; load = 1'b1; clear_req = 1'b1;
    tick();
    load = 1'b0; clear_req = 1'b0;
    check("conf_busy", busy, 1'b1);
    check("conf_w1", out, 16'h0000);
    tick();
    // Load at N+2 while busy is dropped.
    address = 2'd0; din = 16'h7777; load = 1'b1;
    tick();
    load = 1'b0;
    check("busy_wr_w0", out, 16'h0000);
    tick();
    tick();
    check("conf_done", clear_done, 1'b1);
    tick();
    check("conf_idle_done", clear_done, 1'b0);
    // Write one cycle after clear_done is accepted.
    address = 2'd0; din = 16'h7777; load = 1'b1;
    tick();
    load = 1'b0;
    check("post_done_wr", out, 16'h7777);
    address = 2'd1;
    #1;
    check("conf_w1_after", out, 16'h0000);

    // clear_req held high: restarts only after returning to IDLE.
    clear_req = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick();
      check_model($sformatf("held%0d", k));
    end
    clear_req = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      check_model($sformatf("drain%0d", k));
    end

    // Reset in the middle of a clear.
    for (int a = 0; a < 4; a++) begin
      load = 1'b1; address = 2'(a); din = 16'hBEEF;
      tick();
    end
    load = 1'b0;
    sweep("beef", 16'hBEEF);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", clear_done, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("midrst_nodone%0d", k), clear_done, 1'b0);
    end
    sweep("midrst", 16'h0000);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      reset     = ($urandom_range(0, 99) == 0);
      clear_req = ($urandom_range(0, 24) == 0);
      load      = 1'($urandom_range(0, 1));
      address   = 2'($urandom_range(0, 3));
      din       = 16'($urandom);
      #1;
      check_model($sformatf("rand%0d_pre", k));
      tick();
      check_model($sformatf("rand%0d", k));
    end
    reset = 1'b0; load = 1'b0; clear_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
